// File: rtl/dp_ram_be_if.sv
// dp_ram_be_if: port bundle for the dual-port byte-enable RAM (A read/write, B read-only)
interface dp_ram_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int BYTE_W = 8
);
  localparam int NBYTE = DATA_W / BYTE_W;
  logic              ready;
  logic              a_en;
  logic [NBYTE-1:0]  a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_di;
  logic [DATA_W-1:0] a_do;
  logic              a_vld;
  logic              b_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_do;
  logic              b_vld;
  modport master (
    input  ready, a_do, a_vld, b_do, b_vld,
    output a_en, a_we, a_addr, a_di, b_en, b_addr
  );
  modport slave (
    output ready, a_do, a_vld, b_do, b_vld,
    input  a_en, a_we, a_addr, a_di, b_en, b_addr
  );
endinterface

// File: rtl/dp_ram_be.sv
// dp_ram_be: dual-port RAM with byte enables, selectable read-during-write, B forwarding and post-reset clear
module dp_ram_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int BYTE_W   = 8,
  parameter int RDW_MODE = 0,
  parameter int FWD_B    = 0,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1
) (
  input logic        clk,
  input logic        rst_n,
  dp_ram_be_if.slave bus
);
  localparam int NBYTE = DATA_W / BYTE_W;
  typedef enum logic [1:0] {RST, CLEAR, RUN} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              run, a_acc, b_acc;
  logic [DATA_W-1:0] a_old, b_old, a_mrg, a_rd, b_rd;
  logic [DATA_W-1:0] a_q, b_q;
  logic              a_v, b_v;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    run      = state == RUN;
    state_nx = state == RST ? (CLEAR_EN != 0 ? CLEAR : RUN) :
               state == CLEAR && !(&cnt) ? CLEAR : RUN;
  end
  assign bus.ready = run;
  assign a_acc     = run && bus.a_en;
  assign b_acc     = run && bus.b_en;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + ADDR_W'(1);
  // Merged word: written lanes take new data, the rest keep the stored bytes
  always_comb begin
    a_old = mem[bus.a_addr];
    b_old = mem[bus.b_addr];
    a_mrg = a_old;
    for (int i = 0; i < NBYTE; i++)
      if (bus.a_we[i]) a_mrg[i*BYTE_W +: BYTE_W] = bus.a_di[i*BYTE_W +: BYTE_W];
    a_rd = RDW_MODE != 0 ? a_mrg : a_old;
    b_rd = FWD_B != 0 && bus.a_en && bus.a_addr == bus.b_addr ? a_mrg : b_old;
  end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[cnt] <= '0;
    else if (a_acc)
      for (int i = 0; i < NBYTE; i++)
        if (bus.a_we[i]) mem[bus.a_addr][i*BYTE_W +: BYTE_W] <= bus.a_di[i*BYTE_W +: BYTE_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_v <= 1'b0;
      b_v <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_v <= a_acc;
      b_v <= b_acc;
      if (a_acc) a_q <= a_rd;
      if (b_acc) b_q <= b_rd;
    end
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] a_q2, b_q2;
      logic              a_v2, b_v2;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
          a_q2 <= '0;
          b_q2 <= '0;
        end else begin
          a_v2 <= a_v;
          b_v2 <= b_v;
          if (a_v) a_q2 <= a_q;
          if (b_v) b_q2 <= b_q;
        end
      assign bus.a_do  = a_q2;
      assign bus.a_vld = a_v2;
      assign bus.b_do  = b_q2;
      assign bus.b_vld = b_v2;
    end else begin : g_direct
      assign bus.a_do  = a_q;
      assign bus.a_vld = a_v;
      assign bus.b_do  = b_q;
      assign bus.b_vld = b_v;
    end
  endgenerate
endmodule
